// File: rtl/tc11_mod_adder_seq_if.sv
// Operand/result handshake bundle for the modulo-11 thermometer adder.
// The master drives operands and accepts results; the slave is the adder.
interface tc11_mod_adder_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [10:1] a_tc;
  logic [10:1] b_tc;
  logic        out_valid;
  logic        out_ready;
  logic [10:1] sum_tc;
  logic [4:1]  sum_bin;
  logic        code_err;

  modport master (
    output in_valid, a_tc, b_tc, out_ready,
    input  in_ready, out_valid, sum_tc, sum_bin, code_err
  );

  modport slave (
    input  in_valid, a_tc, b_tc, out_ready,
    output in_ready, out_valid, sum_tc, sum_bin, code_err
  );
endinterface

// File: rtl/tc11_mod_adder_seq.sv
// Sequential modulo-11 adder on 10-bit thermometer residues: a is stepped
// once per set bit of b, then the sum is held until the consumer takes it.
module tc11_mod_adder_seq (
  input  logic                 clk,
  input  logic                 rst,
  tc11_mod_adder_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  logic [10:1] r_acc;
  logic [10:1] r_cnt;
  logic        r_err;
  logic        r_in_ready;
  logic        r_out_valid;

  logic        w_bad;
  logic [10:1] w_cnt_shr;

  // A thermometer code has no zero below a one, so x+1 never overlaps x.
  function automatic logic legal(input logic [10:1] x);
    logic [10:0] ext;
    logic [10:0] nxt;
    ext = {1'b0, x};
    nxt = ext + 11'd1;
    return ((ext & nxt) == 11'd0);
  endfunction

  function automatic logic [10:1] inc(input logic [10:1] x);
    if (x == 10'h3FF) return 10'h000;
    return {x[9:1], 1'b1};
  endfunction

  function automatic logic [4:1] popcount(input logic [10:1] x);
    logic [4:1] n;
    n = 4'd0;
    for (int i = 1; i <= 10; i++) n = n + {3'd0, x[i]};
    return n;
  endfunction

  assign w_bad     = !(legal(bus.a_tc) && legal(bus.b_tc));
  assign w_cnt_shr = {1'b0, r_cnt[10:2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= 10'd0;
      r_cnt       <= 10'd0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_acc      <= bus.a_tc;
            r_cnt      <= bus.b_tc;
            r_err      <= w_bad;
            r_in_ready <= 1'b0;
            if (w_bad || bus.b_tc == 10'd0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_acc <= inc(r_acc);
          r_cnt <= w_cnt_shr;
          if (w_cnt_shr == 10'd0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE takes a cycle; no operands are taken here.
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.code_err  = r_err;
  assign bus.sum_tc    = r_err ? 10'd0 : r_acc;
  assign bus.sum_bin   = r_err ? 4'd0 : popcount(r_acc);

endmodule

// File: doc/tc11_mod_adder_seq.md
# tc11_mod_adder_seq

Sequential modulo-11 adder operating on 10-bit thermometer-coded residues. It sits directly downstream of the binary-to-thermometer (mod 11) converters and consumes two of their codes per transaction. It adds operand b to operand a with one modular thermometer increment of a per set bit of b. It returns the sum as a thermometer code and as a 4-bit binary residue, with valid/ready handshakes on both sides.

## Interface
- No parameters. Modulus fixed at 11, code width fixed at 10.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands (high only in IDLE)
- a_tc  in  [10:1]  operand a, thermometer code (0 = all zeros, k = bits k..1 set)
- b_tc  in  [10:1]  operand b, thermometer code
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum_tc  out  [10:1]  (a+b) mod 11, thermometer code
- sum_bin  out  [4:1]  (a+b) mod 11, binary 0..10
- code_err  out  1  at least one operand was not a legal thermometer code

## Operation
- Registers:
  - acc[10:1]: running sum.
  - cnt[10:1]: remaining increments, stored as b.
  - err: error flag.
  - state: IDLE / RUN / DONE.
- Legal code check: x is legal iff (x & (x+1)) == 0, with the addition done at 11 bits. This covers the values 0 and 2^k−1 for k = 1..10.
- Modular increment inc(x):
  - x == 10'h3FF gives 0 (wrap from 10 to 0).
  - Otherwise {x[9:1], 1'b1}.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: acc <= a_tc, cnt <= b_tc, err <= !(legal(a_tc) && legal(b_tc)).
  - Next state is DONE if err is set or b_tc == 0; otherwise RUN.
- RUN, each cycle:
  - acc <= inc(acc).
  - cnt <= cnt >> 1, with a zero shifted into bit 10.
  - Go to DONE when (cnt >> 1) == 0.
  - RUN therefore lasts exactly popcount(b) cycles, 1..10.
- DONE:
  - out_valid = 1.
  - Outputs are held stable until out_valid && out_ready.
  - On that handshake, return to IDLE. No accept occurs in the same cycle.
- Outputs:
  - sum_tc = err ? 0 : acc.
  - sum_bin = err ? 0 : popcount(acc), range 0..10.
  - Both are driven from registers through combinational decode only, with no input-to-output path.
- in_valid seen outside IDLE is ignored: in_ready = 0 there, and the operands are not sampled.

## Timing
- Reset values:
  - state = IDLE; acc = 0; cnt = 0; err = 0.
  - in_ready = 1, out_valid = 0, sum_tc = 0, sum_bin = 0, code_err = 0.
- Reset asserted in any state aborts the operation immediately. The in-flight operands are discarded and no out_valid is produced.
- Latency is measured from the accept edge to the first cycle out_valid = 1:
  - popcount(b) + 1 cycles.
  - b = 0 or an illegal code: 1 cycle.
  - b = 10: 11 cycles.
- Throughput is one transaction per latency + 1 cycles minimum, because DONE → IDLE costs one cycle.
- Backpressure: with out_ready held low, DONE persists indefinitely with all outputs unchanged.
- Boundary cases:
  - a = 10 with b ≥ 1 wraps to 0 on the first increment.
  - a = 0, b = 0 gives a result of 0.
  - a = 10, b = 10 gives 9.

## Test plan
- 3 + 4: a_tc = 0000000111, b_tc = 0000001111 → 5 cycles after accept, out_valid = 1, sum_tc = 0001111111, sum_bin = 7, code_err = 0.
- Wrap cases:
  - 7 + 5: a_tc = 0001111111, b_tc = 0000011111 → sum_bin = 1, sum_tc = 0000000001.
  - 10 + 10 → sum_bin = 9 after 11 cycles.
- Zero operand: a = 6, b_tc = 0 → out_valid in 1 cycle, sum_bin = 6. Then a = 0, b = 0 → sum_bin = 0.
- Illegal code: a_tc = 0000000101, b_tc = 0000000011 → out_valid after 1 cycle, code_err = 1, sum_tc = 0, sum_bin = 0. The next legal transaction clears code_err.
- Backpressure and ignored input: hold out_ready = 0 for 4 cycles in DONE → outputs constant, in_ready = 0, and a new in_valid is not accepted. Raise out_ready → IDLE next cycle, in_ready = 1.
- Reset mid-RUN: assert rst 3 cycles into 2 + 8 → all outputs return to reset values at once. After release, 1 + 1 completes with sum_bin = 2 and no stale result appears.
